// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: base-op encodings, M-op funct3 codes and the FSM state type
// shared by alu_seq and mdu_iter.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b0001;
  localparam logic [3:0] OP_SLT   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_PASSY = 4'b1111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aluState_t;

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: N-step shift-add multiplier / restoring divider working on operand
// magnitudes with a final sign fix. Only built when ALU_SEQ_MDU_EN is defined.
`ifdef ALU_SEQ_MDU_EN
module mdu_iter
  import alu_seq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         dz
);
  localparam int CW = $clog2(N);

  logic [CW-1:0]  count_r;
  logic           busy_r, negRes_r, negRem_r, dzCase_r;
  logic [2:0]     f3_r;
  logic [N-1:0]   accHi_r, accLo_r, mcand_r, xSave_r;

  logic           signedX_s, signedY_s;
  logic [N-1:0]   magX_s, magY_s, addend_s, nextHi_s, nextLo_s, quo_s, rem_s;
  logic [N:0]     addSum_s, shifted_s, diff_s;
  logic [2*N-1:0] prod_s, prodFix_s;

  // Operand signedness per funct3.
  always_comb begin
    signedX_s = 1'b0;
    signedY_s = 1'b0;
    case (funct3)
      F3_MULH:                             begin signedX_s = 1'b1; signedY_s = 1'b1; end
      F3_MULHSU:                           begin signedX_s = 1'b1; signedY_s = 1'b0; end
      F3_DIV, F3_REM:                      begin signedX_s = 1'b1; signedY_s = 1'b1; end
      F3_MUL, F3_MULHU, F3_DIVU, F3_REMU:  begin signedX_s = 1'b0; signedY_s = 1'b0; end
      default:                             begin signedX_s = 1'b0; signedY_s = 1'b0; end
    endcase
  end

  assign magX_s = (signedX_s && X[N-1]) ? -X : X;
  assign magY_s = (signedY_s && Y[N-1]) ? -Y : Y;

  // One iteration: accHi/accLo hold product-high/multiplier or remainder/quotient.
  always_comb begin
    addend_s  = accLo_r[0] ? mcand_r : {N{1'b0}};
    addSum_s  = {1'b0, accHi_r} + {1'b0, addend_s};
    shifted_s = {accHi_r, accLo_r[N-1]};
    diff_s    = shifted_s - {1'b0, mcand_r};
    nextHi_s  = accHi_r;
    nextLo_s  = accLo_r;
    if (f3_r[2]) begin
      if (!diff_s[N]) begin
        nextHi_s = diff_s[N-1:0];
        nextLo_s = {accLo_r[N-2:0], 1'b1};
      end else begin
        nextHi_s = shifted_s[N-1:0];
        nextLo_s = {accLo_r[N-2:0], 1'b0};
      end
    end else begin
      nextHi_s = addSum_s[N:1];
      nextLo_s = {addSum_s[0], accLo_r[N-1:1]};
    end
  end

  // Sign fix and divide-by-zero override on the state after the final step.
  always_comb begin
    prod_s    = {nextHi_s, nextLo_s};
    prodFix_s = prod_s;
    quo_s     = nextLo_s;
    rem_s     = nextHi_s;
    result    = {N{1'b0}};
    if (negRes_r) begin
      prodFix_s = -prod_s;
    end else begin
      prodFix_s = prod_s;
    end
    if (dzCase_r) begin
      quo_s = {N{1'b1}};
      rem_s = xSave_r;
    end else begin
      quo_s = negRes_r ? -nextLo_s : nextLo_s;
      rem_s = negRem_r ? -nextHi_s : nextHi_s;
    end
    if (f3_r[2]) begin
      result = f3_r[1] ? rem_s : quo_s;
    end else begin
      result = (f3_r[1:0] == 2'b00) ? prodFix_s[N-1:0] : prodFix_s[2*N-1:N];
    end
  end

  assign busy = busy_r;
  assign done = busy_r && (count_r == {CW{1'b0}});
  assign dz   = dzCase_r;

  // Operand load on start, then one step per cycle; latency never shortens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      count_r  <= {CW{1'b0}};
      f3_r     <= 3'b000;
      negRes_r <= 1'b0;
      negRem_r <= 1'b0;
      dzCase_r <= 1'b0;
      accHi_r  <= {N{1'b0}};
      accLo_r  <= {N{1'b0}};
      mcand_r  <= {N{1'b0}};
      xSave_r  <= {N{1'b0}};
    end else if (start) begin
      busy_r   <= 1'b1;
      count_r  <= CW'(N - 1);
      f3_r     <= funct3;
      negRes_r <= (signedX_s && X[N-1]) ^ (signedY_s && Y[N-1]);
      negRem_r <= funct3[2] && signedX_s && X[N-1];
      dzCase_r <= funct3[2] && (Y == {N{1'b0}});
      accHi_r  <= {N{1'b0}};
      accLo_r  <= magX_s;
      mcand_r  <= magY_s;
      xSave_r  <= X;
    end else if (busy_r) begin
      accHi_r <= nextHi_s;
      accLo_r <= nextLo_s;
      if (count_r == {CW{1'b0}}) begin
        busy_r <= 1'b0;
      end else begin
        count_r <= count_r - CW'(1);
      end
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq: handshaked integer ALU with registered result and ovf/dz flags.
// Define ALU_SEQ_MDU_EN to add RV32M ops through the iterative mdu_iter engine.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   op,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ovf,
  output logic         dz
);
  localparam int SHW = $clog2(N);

  aluState_t      state_r;
  logic           outValid_r, ovf_r, dz_r;
  logic [N-1:0]   result_r;

  logic [N-1:0]   sum_s, diff_s, baseRes_s, mduResult_s;
  logic [SHW-1:0] shamt_s;
  logic           baseOvf_s, accept_s, goBusy_s, mduDone_s, mduDz_s;

  assign in_ready  = (state_r == IDLE) || ((state_r == DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = outValid_r;
  assign result    = result_r;
  assign ovf       = ovf_r;
  assign dz        = dz_r;

  assign sum_s   = X + Y;
  assign diff_s  = X - Y;
  assign shamt_s = Y[SHW-1:0];

  // Single-cycle base datapath; unused encodings and M ops here give zero.
  always_comb begin
    baseRes_s = {N{1'b0}};
    baseOvf_s = 1'b0;
    if (op[4]) begin
      baseRes_s = {N{1'b0}};
      baseOvf_s = 1'b0;
    end else begin
      case (op[3:0])
        OP_ADD: begin
          baseRes_s = sum_s;
          baseOvf_s = (X[N-1] == Y[N-1]) && (sum_s[N-1] != X[N-1]);
        end
        OP_SUB: begin
          baseRes_s = diff_s;
          baseOvf_s = (X[N-1] != Y[N-1]) && (diff_s[N-1] != X[N-1]);
        end
        OP_SLL:   baseRes_s = X << shamt_s;
        OP_SLT:   baseRes_s = {{(N-1){1'b0}}, ($signed(X) < $signed(Y))};
        OP_SLTU:  baseRes_s = {{(N-1){1'b0}}, (X < Y)};
        OP_XOR:   baseRes_s = X ^ Y;
        OP_SRL:   baseRes_s = X >> shamt_s;
        OP_SRA:   baseRes_s = $signed(X) >>> shamt_s;
        OP_OR:    baseRes_s = X | Y;
        OP_AND:   baseRes_s = X & Y;
        OP_PASSY: baseRes_s = Y;
        default: begin
          baseRes_s = {N{1'b0}};
          baseOvf_s = 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_MDU_EN
  logic mduBusy_s, mduStart_s;

  assign goBusy_s   = op[4];
  assign mduStart_s = accept_s && goBusy_s && !mduBusy_s;

  mdu_iter #(.N(N)) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mduStart_s),
    .funct3 (op[2:0]),
    .X      (X),
    .Y      (Y),
    .busy   (mduBusy_s),
    .done   (mduDone_s),
    .result (mduResult_s),
    .dz     (mduDz_s)
  );
`else
  assign goBusy_s    = 1'b0;
  assign mduDone_s   = 1'b0;
  assign mduResult_s = {N{1'b0}};
  assign mduDz_s     = 1'b0;
`endif

  // Handshake FSM; DONE with out_ready retires and may capture on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      outValid_r <= 1'b0;
      result_r   <= {N{1'b0}};
      ovf_r      <= 1'b0;
      dz_r       <= 1'b0;
    end else if (accept_s) begin
      if (goBusy_s) begin
        state_r    <= BUSY;
        outValid_r <= 1'b0;
      end else begin
        state_r    <= DONE;
        outValid_r <= 1'b1;
        result_r   <= baseRes_s;
        ovf_r      <= baseOvf_s;
        dz_r       <= 1'b0;
      end
    end else begin
      case (state_r)
        IDLE: state_r <= IDLE;
        BUSY: begin
          if (mduDone_s) begin
            state_r    <= DONE;
            outValid_r <= 1'b1;
            result_r   <= mduResult_s;
            ovf_r      <= 1'b0;
            dz_r       <= mduDz_s;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r    <= IDLE;
            outValid_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          outValid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed self-checking bench for alu_seq against
// an arithmetic reference model; M-op scenarios follow ALU_SEQ_MDU_EN.
module tb_alu_seq;
  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rstN, inValid, inReady, outValid, outReady, ovf, dz;
  logic [4:0]  op;
  logic [31:0] xIn, yIn, result;
  int          nCmp = 0;
  int          nFail = 0;

  always #5 clk = ~clk;

  alu_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady), .op(op),
    .X(xIn), .Y(yIn), .out_valid(outValid), .out_ready(outReady),
    .result(result), .ovf(ovf), .dz(dz)
  );

  // Reference: {ovf, dz, result} from plain 64-bit arithmetic.
  function automatic logic [33:0] refModel(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, t;
    logic [63:0] p;
    logic [31:0] r;
    logic v, z;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a});  ub = longint'({32'd0, b});
    r = 32'd0; v = 1'b0; z = 1'b0;
    if (o[4] == 1'b0) begin
      case (o[3:0])
        4'b0000: begin t = sa + sb; r = a + b; v = (t != longint'($signed(r))); end
        4'b1000: begin t = sa - sb; r = a - b; v = (t != longint'($signed(r))); end
        4'b0001: r = a << b[4:0];
        4'b0010: r = (sa < sb) ? 32'd1 : 32'd0;
        4'b0011: r = (ua < ub) ? 32'd1 : 32'd0;
        4'b0100: r = a ^ b;
        4'b0101: r = a >> b[4:0];
        4'b1101: begin t = sa >>> b[4:0]; r = 32'(t); end
        4'b0110: r = a | b;
        4'b0111: r = a & b;
        4'b1111: r = b;
        default: r = 32'd0;
      endcase
    end else begin
`ifdef ALU_SEQ_MDU_EN
      case (o[2:0])
        3'b000: begin p = sa * sb; r = p[31:0]; end
        3'b001: begin p = sa * sb; r = p[63:32]; end
        3'b010: begin p = sa * ub; r = p[63:32]; end
        3'b011: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
        3'b100: begin
          if (b == 32'd0) begin r = 32'hFFFF_FFFF; z = 1'b1; end
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
          else r = 32'(sa / sb);
        end
        3'b101: begin
          if (b == 32'd0) begin r = 32'hFFFF_FFFF; z = 1'b1; end
          else r = a / b;
        end
        3'b110: begin
          if (b == 32'd0) begin r = a; z = 1'b1; end
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
          else r = 32'(sa % sb);
        end
        default: begin
          if (b == 32'd0) begin r = a; z = 1'b1; end
          else r = a % b;
        end
      endcase
`else
      r = 32'd0;
`endif
    end
    return {v, z, r};
  endfunction

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'($urandom_range(0, 16));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rstN = 1'b0; inValid = 1'b0; outReady = 1'b0; op = 5'd0; xIn = 32'd0; yIn = 32'd0;
    repeat (2) @(negedge clk);
    nCmp++; if (outValid !== 1'b0) begin nFail++; $display("FAIL reset_out_valid: got %b want 0", outValid); end
    nCmp++; if ({ovf, dz, result} !== 34'd0) begin nFail++; $display("FAIL reset_outputs: got %h want 0", {ovf, dz, result}); end
    nCmp++; if (inReady !== 1'b1) begin nFail++; $display("FAIL reset_in_ready: got %b want 1", inReady); end
    @(negedge clk) rstN = 1'b1;
    @(negedge clk);
    nCmp++; if (inReady !== 1'b1) begin nFail++; $display("FAIL post_reset_in_ready: got %b want 1", inReady); end
  endtask

  task automatic test_base_stream();
    logic [4:0]  ops[$];
    logic [31:0] xs[$], ys[$];
    logic [33:0] e;
    ops.push_back(5'b00000); xs.push_back(32'h7FFF_FFFF); ys.push_back(32'd1);
    ops.push_back(5'b01000); xs.push_back(32'd5);         ys.push_back(32'd7);
    ops.push_back(5'b01101); xs.push_back(32'h8000_0000); ys.push_back(32'h21);
    for (int i = 0; i < 24; i++) begin
      ops.push_back({1'b0, 4'($urandom_range(0, 15))});
      xs.push_back(pickVal()); ys.push_back(pickVal());
    end
    outReady = 1'b1;
    for (int i = 0; i <= ops.size(); i++) begin
      @(posedge clk); #1;
      if (i < ops.size()) begin inValid = 1'b1; op = ops[i]; xIn = xs[i]; yIn = ys[i]; end
      else inValid = 1'b0;
      @(negedge clk);
      if (i > 0) begin
        e = refModel(ops[i-1], xs[i-1], ys[i-1]);
        nCmp++; if (outValid !== 1'b1) begin nFail++; $display("FAIL stream_valid[%0d]: got %b want 1", i-1, outValid); end
        nCmp++; if ({ovf, dz, result} !== e) begin nFail++; $display("FAIL stream_result[%0d] op=%b: got ovf/dz/res %h want %h", i-1, ops[i-1], {ovf, dz, result}, e); end
      end
      if (i < ops.size()) begin
        nCmp++; if (inReady !== 1'b1) begin nFail++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, inReady); end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    nCmp++; if (outValid !== 1'b0) begin nFail++; $display("FAIL stream_drain: out_valid got %b want 0", outValid); end
  endtask

  // One op with out_ready=1; checks value, flags and latency from presentation.
  task automatic runOp(input string name, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input int expLat);
    logic [33:0] e;
    int lat;
    e = refModel(o, a, b);
    @(posedge clk); #1;
    inValid = 1'b1; op = o; xIn = a; yIn = b; outReady = 1'b1;
    @(negedge clk);
    nCmp++; if (inReady !== 1'b1) begin nFail++; $display("FAIL %s_in_ready: got %b want 1", name, inReady); end
    @(posedge clk); #1;
    inValid = (expLat > 1); op = 5'b00111; xIn = $urandom; yIn = $urandom;
    lat = 1;
    @(negedge clk);
    while (outValid !== 1'b1 && lat < 200) begin
      if (lat == 4) begin
        nCmp++; if (inReady !== 1'b0) begin nFail++; $display("FAIL %s_busy_in_ready: got %b want 0", name, inReady); end
      end
      if (lat == 6) inValid = 1'b0;
      @(negedge clk); lat++;
    end
    inValid = 1'b0;
    nCmp++; if (lat !== expLat) begin nFail++; $display("FAIL %s_latency: got %0d want %0d", name, lat, expLat); end
    nCmp++; if ({ovf, dz, result} !== e) begin nFail++; $display("FAIL %s_result: got ovf/dz/res %h want %h", name, {ovf, dz, result}, e); end
    @(posedge clk); #1;
    @(negedge clk);
    nCmp++; if (outValid !== 1'b0) begin nFail++; $display("FAIL %s_retire: out_valid got %b want 0", name, outValid); end
  endtask

  task automatic test_unused();
    runOp("unused_1010", 5'b01010, $urandom, $urandom, 1);
    runOp("unused_1001", 5'b01001, $urandom, $urandom, 1);
  endtask

  task automatic test_backpressure();
    logic [4:0]  opA, opB;
    logic [31:0] a, b;
    logic [33:0] eA, eB;
    int w, expB;
`ifdef ALU_SEQ_MDU_EN
    opA = 5'b10100; opB = 5'b10110; expB = N + 1;
`else
    opA = 5'b00000; opB = 5'b01000; expB = 1;
`endif
    a = 32'hFFFF_FFF9; b = 32'd2;
    eA = refModel(opA, a, b); eB = refModel(opB, a, b);
    @(posedge clk); #1;
    inValid = 1'b1; op = opA; xIn = a; yIn = b; outReady = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    w = 0;
    @(negedge clk);
    while (outValid !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    nCmp++; if (outValid !== 1'b1) begin nFail++; $display("FAIL bp_first_valid: got %b want 1", outValid); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      inValid = 1'b1; op = opB; xIn = a; yIn = b;
      @(negedge clk);
      nCmp++; if ({outValid, ovf, dz, result} !== {1'b1, eA}) begin nFail++; $display("FAIL bp_hold[%0d]: got v/ovf/dz/res %h want %h", i, {outValid, ovf, dz, result}, {1'b1, eA}); end
      nCmp++; if (inReady !== 1'b0) begin nFail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, inReady); end
    end
    @(posedge clk); #1;
    outReady = 1'b1;
    @(negedge clk);
    nCmp++; if (inReady !== 1'b1) begin nFail++; $display("FAIL bp_release_in_ready: got %b want 1", inReady); end
    @(posedge clk); #1;
    inValid = 1'b0;
    w = 1;
    @(negedge clk);
    while (outValid !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    nCmp++; if (w !== expB) begin nFail++; $display("FAIL bp_second_latency: got %0d want %0d", w, expB); end
    nCmp++; if ({ovf, dz, result} !== eB) begin nFail++; $display("FAIL bp_second_result: got %h want %h", {ovf, dz, result}, eB); end
    @(posedge clk); #1;
  endtask

`ifdef ALU_SEQ_MDU_EN
  task automatic test_mdu();
    runOp("mulh_m2x3", 5'b10001, 32'hFFFF_FFFE, 32'd3, N + 1);
    runOp("mul_m2x3",  5'b10000, 32'hFFFF_FFFE, 32'd3, N + 1);
    runOp("div_ovf",   5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, N + 1);
    runOp("rem_ovf",   5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, N + 1);
    runOp("divu_dz",   5'b10101, 32'd10, 32'd0, N + 1);
    runOp("remu_dz",   5'b10111, 32'd10, 32'd0, N + 1);
    runOp("div_dz",    5'b10100, 32'hFFFF_FFF9, 32'd0, N + 1);
    for (int i = 0; i < 16; i++) begin
      runOp("mdu_rand", {2'b10, 3'($urandom_range(0, 7))}, pickVal(), pickVal(), N + 1);
    end
  endtask

  task automatic test_mdu_reset();
    @(posedge clk); #1;
    inValid = 1'b1; op = 5'b10000; xIn = 32'd7; yIn = 32'd9; outReady = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rstN = 1'b0;
    @(negedge clk);
    nCmp++; if ({outValid, result} !== 33'd0) begin nFail++; $display("FAIL mid_busy_reset: got v/res %h want 0", {outValid, result}); end
    nCmp++; if (inReady !== 1'b1) begin nFail++; $display("FAIL mid_busy_reset_in_ready: got %b want 1", inReady); end
    @(negedge clk) rstN = 1'b1;
    repeat (N + 4) @(negedge clk);
    nCmp++; if (outValid !== 1'b0) begin nFail++; $display("FAIL aborted_op_result: out_valid got %b want 0", outValid); end
    runOp("mul_after_reset", 5'b10000, 32'd7, 32'd9, N + 1);
  endtask
`else
  task automatic test_mop_disabled();
    runOp("mop_disabled",  5'b10000, $urandom, $urandom, 1);
    runOp("mop_disabled2", 5'b10100, 32'd10, 32'd0, 1);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_base_stream();
    test_unused();
    test_backpressure();
`ifdef ALU_SEQ_MDU_EN
    test_mdu();
    test_mdu_reset();
`else
    test_mop_disabled();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
